// File: rtl/song_sequencer.sv
// Play-mode note source: walks a song in an external synchronous note ROM and
// drives the note bus. Each note is held for its beats, then a silence gap follows.
module song_sequencer #(
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int GAP_TICKS      = 1_250_000,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              start,
    input  logic              pause,
    input  logic [1:0]        song_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [9:0]        play_note,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-3:0] note_idx
);

    localparam int TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY,
        GAP,
        DONE
    } state_t;

    state_t              state, state_d;
    logic [9:0]          note_reg, note_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [5:0]          beat_cnt, beat_d;
    logic [TICK_W-1:0]   tick_cnt, tick_d;
    logic [GAP_W-1:0]    gap_cnt, gap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            note_reg <= '0;
            rom_addr <= '0;
            beat_cnt <= '0;
            tick_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_d;
            note_reg <= note_d;
            rom_addr <= addr_d;
            beat_cnt <= beat_d;
            tick_cnt <= tick_d;
            gap_cnt  <= gap_d;
        end
    end

    // Abort beats restart, restart beats pause; pause only freezes PLAY and GAP.
    always_comb begin
        state_d = state;
        note_d  = note_reg;
        addr_d  = rom_addr;
        beat_d  = beat_cnt;
        tick_d  = tick_cnt;
        gap_d   = gap_cnt;
        if (!enable) begin
            state_d = IDLE;
            note_d  = '0;
            beat_d  = '0;
            tick_d  = '0;
            gap_d   = '0;
        end else if (start) begin
            state_d = FETCH;
            note_d  = '0;
            addr_d  = {song_sel, {(ADDR_W-2){1'b0}}};
            beat_d  = '0;
            tick_d  = '0;
            gap_d   = '0;
        end else if (pause && (state == PLAY || state == GAP)) begin
            state_d = state;
        end else begin
            case (state)
                FETCH: state_d = WAIT;
                WAIT: begin
                    if (rom_data[5:0] == 6'd0) begin
                        state_d = DONE;
                    end else begin
                        note_d  = rom_data[15:6];
                        beat_d  = rom_data[5:0];
                        tick_d  = '0;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_d = '0;
                        beat_d = beat_cnt - 6'd1;
                        if (beat_cnt == 6'd1) begin
                            note_d  = '0;
                            gap_d   = '0;
                            state_d = GAP;
                        end
                    end else begin
                        tick_d = tick_cnt + TICK_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_d = '0;
                        // The last slot of a song ends it; the address never crosses into the next song.
                        if (&note_idx) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = rom_addr + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        gap_d = gap_cnt + GAP_W'(1);
                    end
                end
                default: state_d = state;
            endcase
        end
    end

    assign play_note = (state == PLAY && !pause) ? note_reg : 10'd0;
    assign playing   = (state == FETCH) || (state == WAIT) || (state == PLAY) || (state == GAP);
    assign done      = (state == DONE);
    assign note_idx  = rom_addr[ADDR_W-3:0];

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a per-cycle expected-output queue is
// built from the ROM contents whenever a song is started and drained against the DUT.
module tb_song_sequencer;

    localparam int TPB = 4;
    localparam int GAP = 2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        start;
    logic        pause;
    logic [1:0]  song_sel;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [9:0]  play_note;
    logic        playing;
    logic        done;
    logic [5:0]  note_idx;

    logic [15:0] rom [256];

    typedef struct {
        string      tag;
        logic [9:0] note;
        logic       playing;
        logic       done;
        logic [7:0] addr;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    song_sequencer #(
        .TICKS_PER_BEAT(TPB),
        .GAP_TICKS(GAP),
        .ADDR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .start(start),
        .pause(pause),
        .song_sel(song_sel),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .play_note(play_note),
        .playing(playing),
        .done(done),
        .note_idx(note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic pushSnap(input string tag, input logic [9:0] note, input logic pl,
                            input logic dn, input logic [7:0] addr);
        snap_t s;
        s.tag     = tag;
        s.note    = note;
        s.playing = pl;
        s.done    = dn;
        s.addr    = addr;
        exp_q.push_back(s);
    endtask

    task automatic checkField(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare the DUT against the queue head; while paused the head stays queued and the note reads silent.
    task automatic checkOutput(input bit silent);
        snap_t e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL empty_queue observed=0 expected=1");
            return;
        end
        e = exp_q[0];
        if (silent) e.note = 10'd0;
        else void'(exp_q.pop_front());
        checkField({e.tag, ".note"},    16'(play_note), 16'(e.note));
        checkField({e.tag, ".playing"}, 16'(playing),   16'(e.playing));
        checkField({e.tag, ".done"},    16'(done),      16'(e.done));
        checkField({e.tag, ".addr"},    16'(rom_addr),  16'(e.addr));
        checkField({e.tag, ".idx"},     16'(note_idx),  16'(e.addr[5:0]));
    endtask

    task automatic applyStimulus(input logic [1:0] sel);
        song_sel = sel;
        start    = 1'b1;
        stepClock();
        start    = 1'b0;
    endtask

    // Expected timeline from the start edge: FETCH, WAIT, dur*TPB note cycles, GAP silent cycles, ...
    task automatic pushSong(input logic [1:0] sel);
        logic [7:0]  addr;
        logic [15:0] w;
        bit          finished;
        addr = {sel, 6'd0};
        finished = 0;
        pushSnap($sformatf("s%0d_fetch0", sel), 10'd0, 1'b1, 1'b0, addr);
        pushSnap($sformatf("s%0d_wait0", sel), 10'd0, 1'b1, 1'b0, addr);
        for (int i = 0; i < 64 && !finished; i++) begin
            addr = {sel, 6'(i)};
            w = rom[addr];
            if (w[5:0] == 6'd0) begin
                pushSnap($sformatf("s%0d_end%0d", sel, i), 10'd0, 1'b0, 1'b1, addr);
                finished = 1;
            end else begin
                for (int c = 0; c < int'(w[5:0]) * TPB; c++)
                    pushSnap($sformatf("s%0d_n%0d_c%0d", sel, i, c), w[15:6], 1'b1, 1'b0, addr);
                for (int c = 0; c < GAP; c++)
                    pushSnap($sformatf("s%0d_g%0d_c%0d", sel, i, c), 10'd0, 1'b1, 1'b0, addr);
                if (i == 63) begin
                    pushSnap($sformatf("s%0d_last", sel), 10'd0, 1'b0, 1'b1, addr);
                    finished = 1;
                end else begin
                    pushSnap($sformatf("s%0d_fetch%0d", sel, i + 1), 10'd0, 1'b1, 1'b0, addr + 8'd1);
                    pushSnap($sformatf("s%0d_wait%0d", sel, i + 1), 10'd0, 1'b1, 1'b0, addr + 8'd1);
                end
            end
        end
    endtask

    task automatic runQueue(input int max_cycles, input int pause_at, input int pause_len);
        bit p;
        for (int n = 0; n < max_cycles && exp_q.size() > 0; n++) begin
            if (n > 0) stepClock();
            p = (n >= pause_at) && (n < pause_at + pause_len);
            pause = p;
            checkOutput(p);
        end
        pause = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h0042;
        rom[8'h01] = 16'h2081;
        rom[8'h02] = 16'h0000;
        rom[8'h80] = 16'h4001;
        rom[8'h81] = 16'h0C02;
        rom[8'h82] = 16'h0000;
        for (int i = 0; i < 64; i++)
            rom[8'hC0 + i] = {3'(i % 8), 7'(1 << (i % 7)), 6'd1};

        rst = 1'b1; enable = 1'b0; start = 1'b0; pause = 1'b0; song_sel = 2'd0;
        repeat (3) stepClock();
        pushSnap("reset", 10'd0, 1'b0, 1'b0, 8'h00);
        checkOutput(0);
        rst = 1'b0;
        enable = 1'b1;
        stepClock();

        $display("[TB] basic playback of song 0");
        applyStimulus(2'd0);
        pushSong(2'd0);
        runQueue(1000, 1000, 0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            pushSnap("done_hold", 10'd0, 1'b0, 1'b1, 8'h02);
            checkOutput(0);
        end

        $display("[TB] pause during first note");
        applyStimulus(2'd0);
        pushSong(2'd0);
        runQueue(1000, 4, 5);

        $display("[TB] abort during second note");
        applyStimulus(2'd0);
        pushSong(2'd0);
        runQueue(16, 1000, 0);
        exp_q.delete();
        enable = 1'b0;
        stepClock();
        pushSnap("abort", 10'd0, 1'b0, 1'b0, 8'h01);
        checkOutput(0);
        applyStimulus(2'd2);
        pushSnap("start_disabled", 10'd0, 1'b0, 1'b0, 8'h01);
        checkOutput(0);
        enable = 1'b1;
        stepClock();
        pushSnap("idle_after_abort", 10'd0, 1'b0, 1'b0, 8'h01);
        checkOutput(0);

        $display("[TB] restart into song 2");
        applyStimulus(2'd0);
        pushSong(2'd0);
        runQueue(6, 1000, 0);
        exp_q.delete();
        applyStimulus(2'd2);
        pushSong(2'd2);
        runQueue(1000, 1000, 0);

        $display("[TB] full song 3 without end marker");
        applyStimulus(2'd3);
        pushSong(2'd3);
        runQueue(2000, 1000, 0);

        $display("[TB] reset during playback");
        applyStimulus(2'd0);
        pushSong(2'd0);
        runQueue(6, 1000, 0);
        exp_q.delete();
        rst = 1'b1;
        start = 1'b1;
        stepClock();
        pushSnap("rst_mid", 10'd0, 1'b0, 1'b0, 8'h00);
        checkOutput(0);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            pushSnap("idle_after_rst", 10'd0, 1'b0, 1'b0, 8'h00);
            checkOutput(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
